// File: rtl/ex_mdu.sv
// ---------------------------------------------------------------------------
// ex_mdu -- multiply / divide unit for the execute stage.
//
// Multiplies (MULT/MULTU) finish in one cycle. Divides (DIV/DIVU) run a
// restoring shift-subtract loop, one quotient bit per cycle. The result is
// presented for exactly one cycle on ready_o/whilo_o.
//
// Optional feature (macro EX_MDU_MACC_EN):
//   defined   -> MADD/MADDU/MSUB/MSUBU accumulate the product into {hi_i,lo_i}
//   undefined -> ops 4..7 are rejected and no accumulate adder is built
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start_i, op_i   operation request (sampled in IDLE only) and opcode
//   opdata1_i/2_i   multiplicand/dividend and multiplier/divisor
//   hi_i, lo_i      accumulate base, captured at start
//   annul_i         abort whatever is in flight
//   stallreq_o      pipeline stall request (combinational)
//   ready_o         one-cycle result-valid pulse; whilo_o mirrors it
//   hi_o, lo_o      result (remainder/quotient for divides), 0 when not ready
// ---------------------------------------------------------------------------
module ex_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] opdata1_i,
    input  logic [WIDTH-1:0] opdata2_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic             annul_i,
    output logic             stallreq_o,
    output logic             ready_o,
    output logic             whilo_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int               CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIV_ON = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // hi/lo double as remainder/quotient-shift registers during a divide.
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic             quot_neg_q, quot_neg_d;
    logic             rem_neg_q, rem_neg_d;

    // ---------------------------------------------------------------- decode
    logic op_signed, op_div, op_ok, accept;

    // Even opcodes are the signed flavours in every family.
    assign op_signed = ~op_i[0];
    assign op_div    = (op_i[2:1] == 2'b01);
`ifdef EX_MDU_MACC_EN
    assign op_ok     = 1'b1;
`else
    assign op_ok     = ~op_i[2];
`endif
    assign accept    = (state_q == IDLE) && start_i && !annul_i && !rst && op_ok;

    // ------------------------------------------------ operand magnitudes
    // Both multiply and divide work on magnitudes; the sign is reapplied
    // afterwards, so a single unsigned WIDTH x WIDTH multiplier suffices.
    logic             neg1, neg2;
    logic [WIDTH-1:0] mag1, mag2;

    assign neg1 = op_signed & opdata1_i[WIDTH-1];
    assign neg2 = op_signed & opdata2_i[WIDTH-1];
    assign mag1 = neg1 ? -opdata1_i : opdata1_i;
    assign mag2 = neg2 ? -opdata2_i : opdata2_i;

    logic [2*WIDTH-1:0] prod_mag, prod, mul_res;

    assign prod_mag = {{WIDTH{1'b0}}, mag1} * {{WIDTH{1'b0}}, mag2};
    assign prod     = (neg1 ^ neg2) ? -prod_mag : prod_mag;

`ifdef EX_MDU_MACC_EN
    logic [2*WIDTH-1:0] acc_base;

    assign acc_base = {hi_i, lo_i};
    // op_i[1] separates MSUB/MSUBU from MADD/MADDU.
    assign mul_res  = op_i[2] ? (op_i[1] ? acc_base - prod : acc_base + prod) : prod;
`else
    logic unused_acc_base;

    assign unused_acc_base = ^{hi_i, lo_i};
    assign mul_res         = prod;
`endif

    // ------------------------------------------------------ divider step
    // partial < 2*divisor always holds, so the top bit of a WIDTH+1-bit
    // difference is a reliable "partial < divisor" flag.
    logic [WIDTH:0]   partial, diff;
    logic             ge;
    logic [WIDTH-1:0] step_rem, step_quot;

    assign partial   = {hi_q, lo_q[WIDTH-1]};
    assign diff      = partial - {1'b0, divisor_q};
    assign ge        = ~diff[WIDTH];
    assign step_rem  = ge ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    assign step_quot = {lo_q[WIDTH-2:0], ge};

    // --------------------------------------------------- next-state logic
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves a
        // latch behind.
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        divisor_d  = divisor_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!op_div) begin
                        {hi_d, lo_d} = mul_res;
                        state_d      = DONE;
                    end else if (opdata2_i == '0) begin
                        hi_d    = '0;
                        lo_d    = '0;
                        state_d = DONE;
                    end else begin
                        hi_d       = '0;
                        lo_d       = mag1;
                        divisor_d  = mag2;
                        quot_neg_d = neg1 ^ neg2;
                        rem_neg_d  = neg1;
                        cnt_d      = '0;
                        state_d    = DIV_ON;
                    end
                end
            end
            DIV_ON: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    // Final step: fold the sign correction in on the way out.
                    hi_d    = rem_neg_q  ? -step_rem  : step_rem;
                    lo_d    = quot_neg_q ? -step_quot : step_quot;
                    state_d = DONE;
                end else begin
                    hi_d = step_rem;
                    lo_d = step_quot;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (annul_i) begin
            state_d = IDLE;
        end
    end

    // ----------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            divisor_q  <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            divisor_q  <= divisor_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
        end
    end

    // ------------------------------------------------------------- outputs
    assign ready_o    = (state_q == DONE) && !annul_i;
    assign whilo_o    = ready_o;
    assign hi_o       = ready_o ? hi_q : '0;
    assign lo_o       = ready_o ? lo_q : '0;
    assign stallreq_o = accept || ((state_q == DIV_ON) && !rst);

endmodule
